// File: rtl/rgb_frame_writer_if.sv
// rtl/rgb_frame_writer_if.sv - pixel stream in, pixel RAM write port and frame status out
interface rgb_frame_writer_if;
  logic        rgb_enable;
  logic [23:0] rgb;
  logic        rgb_valid;
  logic        hsync;
  logic        vsync;
  logic [31:0] ram_waddr;
  logic [15:0] ram_wdata;
  logic        w_enable;
  logic        read_bank;
  logic        stream_ready;
  logic        frame_error;

  modport slave (
    input  rgb_enable, rgb, rgb_valid, hsync, vsync,
    output ram_waddr, ram_wdata, w_enable, read_bank, stream_ready, frame_error
  );

  modport master (
    output rgb_enable, rgb, rgb_valid, hsync, vsync,
    input  ram_waddr, ram_wdata, w_enable, read_bank, stream_ready, frame_error
  );
endinterface

// File: rtl/rgb_frame_writer.sv
// rtl/rgb_frame_writer.sv - captures an RGB888 stream and writes RGB565 frames into a double-buffered pixel RAM
// A bank is handed to the reader only after a frame with exactly HEIGHT lines of WIDTH pixels lands in it.
module rgb_frame_writer #(
  parameter int unsigned WIDTH       = 1920,
  parameter int unsigned HEIGHT      = 1080,
  parameter int unsigned BANK_BASE_0 = 0,
  parameter int unsigned BANK_BASE_1 = 2097152
) (
  input logic               clk,
  input logic               nrst,
  rgb_frame_writer_if.slave bus
);
  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t      state_q;
  logic        hsync_q;
  logic        vsync_q;
  logic [31:0] col_q;
  logic [31:0] line_q;
  logic [31:0] line_base_q;
  logic        bad_q;
  logic        write_bank_q;
  logic [31:0] ram_waddr_q;
  logic [15:0] ram_wdata_q;
  logic        w_enable_q;
  logic        read_bank_q;
  logic        stream_ready_q;
  logic        frame_error_q;

  logic        hs_rise;
  logic        vs_rise;
  logic        pix_in_range;
  logic        pix_write;
  logic        frame_good;
  logic [31:0] col_d;
  logic [31:0] write_base;
  logic [15:0] rgb565;

  assign hs_rise      = bus.hsync & ~hsync_q;
  assign vs_rise      = bus.vsync & ~vsync_q;
  assign pix_in_range = (col_q < WIDTH) && (line_q < HEIGHT);
  assign pix_write    = bus.rgb_valid && pix_in_range;
  // A pixel arriving with the hsync edge still counts toward the line it ends.
  assign col_d        = pix_write ? col_q + 32'd1 : col_q;
  assign frame_good   = (line_q == HEIGHT) && !bad_q;
  assign write_base   = write_bank_q ? BANK_BASE_1 : BANK_BASE_0;
  assign rgb565       = {bus.rgb[23:19], bus.rgb[15:10], bus.rgb[7:3]};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q        <= IDLE;
      hsync_q        <= 1'b0;
      vsync_q        <= 1'b0;
      col_q          <= '0;
      line_q         <= '0;
      line_base_q    <= '0;
      bad_q          <= 1'b0;
      write_bank_q   <= 1'b1;
      ram_waddr_q    <= '0;
      ram_wdata_q    <= '0;
      w_enable_q     <= 1'b0;
      read_bank_q    <= 1'b0;
      stream_ready_q <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      hsync_q    <= bus.hsync;
      vsync_q    <= bus.vsync;
      w_enable_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (vs_rise && bus.rgb_enable) begin
            state_q     <= CAPTURE;
            col_q       <= '0;
            line_q      <= '0;
            line_base_q <= '0;
            bad_q       <= 1'b0;
          end
        end
        CAPTURE: begin
          if (vs_rise) begin
            if (frame_good) begin
              read_bank_q    <= write_bank_q;
              write_bank_q   <= read_bank_q;
              stream_ready_q <= 1'b1;
            end else begin
              frame_error_q  <= 1'b1;
            end
            col_q       <= '0;
            line_q      <= '0;
            line_base_q <= '0;
            bad_q       <= 1'b0;
            state_q     <= bus.rgb_enable ? CAPTURE : IDLE;
          end else begin
            if (pix_write) begin
              w_enable_q  <= 1'b1;
              ram_wdata_q <= rgb565;
              ram_waddr_q <= write_base + line_base_q + col_q;
            end
            if ((bus.rgb_valid && !pix_in_range) || (hs_rise && (col_d != WIDTH))) begin
              bad_q <= 1'b1;
            end
            if (hs_rise) begin
              col_q <= '0;
              if (line_q < HEIGHT) begin
                line_q      <= line_q + 32'd1;
                line_base_q <= line_base_q + WIDTH;
              end
            end else begin
              col_q <= col_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ram_waddr    = ram_waddr_q;
  assign bus.ram_wdata    = ram_wdata_q;
  assign bus.w_enable     = w_enable_q;
  assign bus.read_bank    = read_bank_q;
  assign bus.stream_ready = stream_ready_q;
  assign bus.frame_error  = frame_error_q;
endmodule

// File: tb/tb_rgb_frame_writer.sv
// tb/tb_rgb_frame_writer.sv - self-checking bench for rgb_frame_writer with a frame-level model
module tb_rgb_frame_writer;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned B0 = 0;
  localparam int unsigned B1 = 32'h100;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  rgb_frame_writer_if bus ();

  rgb_frame_writer #(
    .WIDTH(W), .HEIGHT(H), .BANK_BASE_0(B0), .BANK_BASE_1(B1)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .bus(bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_addr_q[$];
  logic [15:0] exp_data_q[$];
  int          m_lens[$];
  bit          m_active = 1'b0;
  bit          m_enable = 1'b0;
  bit          m_rb     = 1'b0;
  bit          m_ready  = 1'b0;
  bit          m_err    = 1'b0;
  int          n_writes = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] first_waddr = '0;
  logic [15:0] last_wdata = '0;
  bit          done = 1'b0;

  function automatic logic [15:0] to565(logic [23:0] c);
    int r, g, b;
    r = int'(c[23:16]);
    g = int'(c[15:8]);
    b = int'(c[7:0]);
    return 16'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Status is checked every cycle; every write must match the head of the expected-write queue.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (done) break;
      chk("read_bank", 32'(bus.read_bank), 32'(m_rb));
      chk("stream_ready", 32'(bus.stream_ready), 32'(m_ready));
      chk("frame_error", 32'(bus.frame_error), 32'(m_err));
      if (bus.w_enable === 1'b1) begin
        if (exp_addr_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: actual addr=%0h data=%0h required no write",
                   bus.ram_waddr, bus.ram_wdata);
        end else begin
          chk("waddr", bus.ram_waddr, exp_addr_q.pop_front());
          chk("wdata", 32'(bus.ram_wdata), 32'(exp_data_q.pop_front()));
        end
        if (n_writes == 0) first_waddr = bus.ram_waddr;
        n_writes++;
        last_waddr = bus.ram_waddr;
        last_wdata = bus.ram_wdata;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  task automatic idle_cycle();
    @(negedge clk);
    bus.rgb_valid = 1'b0;
    bus.hsync     = 1'b0;
    bus.vsync     = 1'b0;
  endtask

  task automatic set_enable(input bit en);
    bus.rgb_enable = en;
    m_enable       = en;
  endtask

  task automatic pixel(input int p, input bit hs, input logic [23:0] c);
    int k;
    k = m_lens.size();
    @(negedge clk);
    bus.rgb_valid = 1'b1;
    bus.rgb       = c;
    bus.hsync     = hs;
    bus.vsync     = 1'b0;
    if (m_active && k < int'(H) && p < int'(W)) begin
      exp_addr_q.push_back((m_rb ? B0 : B1) + 32'(k) * W + 32'(p));
      exp_data_q.push_back(to565(c));
    end
  endtask

  task automatic send_line(input int len, input bit hs_last, input bit fixed);
    for (int p = 0; p < len; p++)
      pixel(p, hs_last && (p == len - 1), fixed ? 24'hFF8040 : 24'($urandom));
    if (!hs_last) begin
      @(negedge clk);
      bus.rgb_valid = 1'b0;
      bus.hsync     = 1'b1;
    end
    idle_cycle();
    if (m_active) m_lens.push_back(len);
  endtask

  task automatic vsync_pulse(input bit with_pix);
    bit good;
    @(negedge clk);
    bus.vsync     = 1'b1;
    bus.hsync     = 1'b0;
    bus.rgb_valid = with_pix;
    bus.rgb       = 24'h123456;
    if (m_active) begin
      good = (m_lens.size() == int'(H));
      foreach (m_lens[i]) if (m_lens[i] != int'(W)) good = 1'b0;
      if (good) begin
        m_rb    = !m_rb;
        m_ready = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    m_lens.delete();
    m_active = m_enable;
    idle_cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst          = 1'b0;
    bus.rgb_valid = 1'b0;
    bus.hsync     = 1'b0;
    bus.vsync     = 1'b0;
    m_active = 1'b0;
    m_rb     = 1'b0;
    m_ready  = 1'b0;
    m_err    = 1'b0;
    m_lens.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
    n_writes = 0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_waddr"}, bus.ram_waddr, 32'h0);
    chk({tag, "_wdata"}, 32'(bus.ram_wdata), 32'h0);
    chk({tag, "_wen"}, 32'(bus.w_enable), 32'h0);
    chk({tag, "_read_bank"}, 32'(bus.read_bank), 32'h0);
    chk({tag, "_ready"}, 32'(bus.stream_ready), 32'h0);
    chk({tag, "_error"}, 32'(bus.frame_error), 32'h0);
  endtask

  initial begin
    nrst           = 1'b0;
    bus.rgb_enable = 1'b0;
    bus.rgb        = '0;
    bus.rgb_valid  = 1'b0;
    bus.hsync      = 1'b0;
    bus.vsync      = 1'b0;
    do_reset();
    check_reset_outputs("reset");

    // Capture disabled: everything ignored.
    vsync_pulse(1'b0);
    send_line(4, 1'b0, 1'b1);
    send_line(4, 1'b0, 1'b1);
    vsync_pulse(1'b0);
    chk("idle_no_writes", 32'(n_writes), 32'd0);

    // Perfect frame into bank 1.
    set_enable(1'b1);
    vsync_pulse(1'b0);
    send_line(4, 1'b0, 1'b1);
    send_line(4, 1'b0, 1'b1);
    vsync_pulse(1'b0);
    chk("f1_read_bank", 32'(bus.read_bank), 32'd1);
    chk("f1_ready", 32'(bus.stream_ready), 32'd1);
    chk("f1_error", 32'(bus.frame_error), 32'd0);
    chk("f1_nwrites", 32'(n_writes), 32'd8);
    chk("f1_first_addr", first_waddr, 32'h100);
    chk("f1_last_addr", last_waddr, 32'h107);
    chk("f1_last_data", 32'(last_wdata), 32'hFC08);
    chk("f1_model_rb", 32'(m_rb), 32'd1);

    // Second perfect frame into bank 0, last pixel sharing the hsync edge.
    send_line(4, 1'b1, 1'b0);
    send_line(4, 1'b1, 1'b0);
    vsync_pulse(1'b0);
    chk("f2_read_bank", 32'(bus.read_bank), 32'd0);

    // Short line.
    send_line(3, 1'b0, 1'b0);
    send_line(4, 1'b0, 1'b0);
    vsync_pulse(1'b0);
    chk("short_error", 32'(bus.frame_error), 32'd1);
    chk("short_read_bank", 32'(bus.read_bank), 32'd0);
    chk("short_ready", 32'(bus.stream_ready), 32'd1);

    // Extra pixel.
    send_line(4, 1'b0, 1'b0);
    send_line(5, 1'b0, 1'b0);
    vsync_pulse(1'b0);
    chk("extra_read_bank", 32'(bus.read_bank), 32'd0);

    // Good frame after errors, stray pixel on the closing vsync.
    send_line(4, 1'b0, 1'b0);
    send_line(4, 1'b0, 1'b0);
    vsync_pulse(1'b1);
    chk("f5_read_bank", 32'(bus.read_bank), 32'd1);

    // Enable dropped mid-frame: frame completes, then idle.
    send_line(4, 1'b0, 1'b0);
    set_enable(1'b0);
    send_line(4, 1'b0, 1'b0);
    vsync_pulse(1'b0);
    chk("f6_read_bank", 32'(bus.read_bank), 32'd0);
    send_line(4, 1'b0, 1'b0);
    send_line(4, 1'b0, 1'b0);
    vsync_pulse(1'b0);

    // Reset mid-line.
    set_enable(1'b1);
    vsync_pulse(1'b0);
    pixel(0, 1'b0, 24'hABCDEF);
    pixel(1, 1'b0, 24'h13579B);
    idle_cycle();
    chk("pre_reset_addr", last_waddr, 32'h101);
    do_reset();
    check_reset_outputs("midreset");

    vsync_pulse(1'b0);
    send_line(4, 1'b0, 1'b1);
    send_line(4, 1'b0, 1'b1);
    vsync_pulse(1'b0);
    chk("post_first_addr", first_waddr, 32'h100);
    chk("post_nwrites", 32'(n_writes), 32'd8);
    chk("post_read_bank", 32'(bus.read_bank), 32'd1);
    chk("post_error", 32'(bus.frame_error), 32'd0);

    idle_cycle();
    idle_cycle();
    chk("pending_writes", 32'(exp_addr_q.size()), 32'd0);
    done = 1'b1;
    @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
